// File: rtl/fetch_defs.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction size and the default reset vector.
package fetch_defs;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetchState_t;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

  function automatic logic [63:0] alignPc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: reset vector, sequential step of one instruction,
// or redirect target, always word aligned.
module fetch_pc_reg
  import fetch_defs::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [63:0] redirectPc_i,
  input  logic        advance_i,
  input  logic [63:0] basePc_i,
  output logic [63:0] fetchPc_o
);

  logic [63:0] fetchPc_q;
  logic [63:0] fetchPc_d;

  // A redirect outranks the sequential step; the add wraps at 2^64 by width.
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (redirect_i) begin
      fetchPc_d = alignPc(redirectPc_i);
    end else if (advance_i) begin
      fetchPc_d = alignPc(basePc_i + 64'(INST_BYTES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q <= alignPc(RESET_PC);
    end else begin
      fetchPc_q <= fetchPc_d;
    end
  end

  assign fetchPc_o = fetchPc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: requests one word at a time, buffers it for the
// decoder, and drops responses made stale by a redirect.
module inst_fetch_unit
  import fetch_defs::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  fetchState_t state_q;
  logic        instValid_q;
  logic [31:0] inst_q;
  logic [63:0] instPc_q;
  logic [63:0] fetchPc;
  logic        advance;

  assign advance = (state_q == HOLD) && inst_ready && !redirect;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_fetch_pc_reg (
    .clk          (clk),
    .reset        (reset),
    .redirect_i   (redirect),
    .redirectPc_i (redirect_pc),
    .advance_i    (advance),
    .basePc_i     (instPc_q),
    .fetchPc_o    (fetchPc)
  );

  // An ack arriving together with a redirect carries the old path's word, so
  // it is dropped and the new target is requested straight away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= REQ;
      instValid_q <= 1'b0;
      inst_q      <= 32'h0;
      instPc_q    <= 64'h0;
    end else begin
      case (state_q)
        REQ: begin
          if (redirect) begin
            state_q <= imem_ack ? REQ : FLUSH;
          end else if (imem_ack) begin
            inst_q      <= imem_rdata;
            instPc_q    <= fetchPc;
            instValid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || inst_ready) begin
            instValid_q <= 1'b0;
            state_q     <= REQ;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= REQ;
        end
      endcase
    end
  end

  assign imem_req   = (state_q == REQ) && !reset;
  assign imem_addr  = fetchPc;
  assign inst_valid = instValid_q;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, then a randomized run scored
// against a program-order fetch model and a latency-configurable memory.
module tb_inst_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  logic        req2;
  logic [63:0] addr2;
  logic        ack2;
  logic        valid2;
  logic [31:0] inst2;
  logic [63:0] pc2;

  int vectorCount = 0;
  int missCount   = 0;

  bit          memPending;
  logic [63:0] memAddr;
  int          memCount;
  int          memDelay;
  bit          memRandom;

  logic [63:0] expectedPc;
  logic [63:0] nextFetch;
  int          acceptCount;
  int          idleCycles;
  bit          sawStale10;
  logic [63:0] acceptLog[$];
  logic [63:0] wrapLog[$];

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  inst_fetch_unit #(.RESET_PC(WRAP_PC)) dutWrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(32'h0000_0013), .redirect(1'b0),
    .redirect_pc(64'h0), .inst_valid(valid2), .inst_ready(1'b1),
    .inst(inst2), .inst_pc(pc2)
  );

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample before the edge, then update memory and fetch models.
  task automatic applyStimulus();
    logic        pReset, pReq, pAck, pValid, pReady, pRedirect, pReq2, pAck2;
    logic [63:0] pAddr, pPc, pTarget, pAddr2;
    logic [31:0] pInst;
    #1;
    pReset = reset; pReq = imem_req; pAck = imem_ack; pValid = inst_valid;
    pReady = inst_ready; pRedirect = redirect; pAddr = imem_addr; pPc = inst_pc;
    pInst = inst; pTarget = redirect_pc & ~64'h3;
    pReq2 = req2; pAck2 = ack2; pAddr2 = addr2;
    if (pReset) begin
      checkOutput("req_low_in_reset", 64'(pReq), 64'h0);
    end else begin
      checkOutput("addr_aligned", 64'(pAddr[1:0]), 64'h0);
      if (pValid) checkOutput("no_req_while_holding", 64'(pReq), 64'h0);
      if (memPending && pReq) checkOutput("req_addr_stable", pAddr, memAddr);
    end

    @(posedge clk);
    #1;

    if (pReset) begin
      memPending = 0; imem_ack = 1'b0; ack2 = 1'b0;
      expectedPc = RESET_PC; nextFetch = RESET_PC; idleCycles = 0;
      wrapLog.delete();
      checkOutput("valid_after_reset", 64'(inst_valid), 64'h0);
    end else begin
      if (pAck) begin
        memPending = 0;
      end else if (!memPending && pReq) begin
        checkOutput("fetch_addr", pAddr, nextFetch);
        memPending = 1; memAddr = pAddr;
        memCount = memRandom ? int'($urandom_range(0, 3)) : memDelay;
        nextFetch = nextFetch + 64'd4;
      end
      if (pRedirect) nextFetch = pTarget;

      if (pValid && pReady && !pRedirect) begin
        checkOutput("accept_pc", pPc, expectedPc);
        checkOutput("accept_inst", 64'(pInst), 64'(memWord(expectedPc)));
        acceptLog.push_back(pPc);
        acceptCount++;
        expectedPc = expectedPc + 64'd4;
        idleCycles = 0;
      end else begin
        idleCycles++;
      end
      if (pRedirect) begin
        expectedPc = pTarget;
        idleCycles = 0;
        checkOutput("valid_cleared_by_redirect", 64'(inst_valid), 64'h0);
      end
      if (pValid && !pReady && !pRedirect) begin
        checkOutput("stall_valid", 64'(inst_valid), 64'h1);
        checkOutput("stall_inst", 64'(inst), 64'(pInst));
        checkOutput("stall_pc", inst_pc, pPc);
      end
      if (pAck && pReq && !pRedirect) checkOutput("valid_after_ack", 64'(inst_valid), 64'h1);
      if (inst_valid && !pValid) checkOutput("valid_rise_needs_ack", 64'(pAck), 64'h1);
      if (inst_valid && inst_pc == 64'h10) sawStale10 = 1;
      checkOutput("progress_watchdog", 64'(idleCycles <= 60), 64'h1);
      if (idleCycles > 60) idleCycles = 0;

      if (memPending && memCount == 0) begin
        imem_ack = 1'b1; imem_rdata = memWord(memAddr);
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom();
        if (memPending) memCount--;
      end

      if (pReq2 && !pAck2 && wrapLog.size() < 2) wrapLog.push_back(pAddr2);
      ack2 = pReq2 && !pAck2;
      if (valid2) checkOutput("wrap_inst", 64'(inst2), 64'h13);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 64'h0; inst_ready = 1'b1; ack2 = 1'b0;
    memDelay = 0; memRandom = 0; memPending = 0; memAddr = 64'h0; memCount = 0;
    expectedPc = RESET_PC; nextFetch = RESET_PC; acceptCount = 0; idleCycles = 0;
    sawStale10 = 0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_inst_valid", 64'(inst_valid), 64'h0);
    checkOutput("reset_inst", 64'(inst), 64'h0);
    checkOutput("reset_inst_pc", inst_pc, 64'h0);
    checkOutput("reset_imem_req", 64'(imem_req), 64'h0);
    reset = 1'b0;
    #1;
    checkOutput("first_req", 64'(imem_req), 64'h1);
    checkOutput("first_addr", imem_addr, RESET_PC);
    checkOutput("wrap_first_addr", addr2, WRAP_PC);

    for (int i = 0; i < 40 && acceptCount < 2; i++) applyStimulus();
    checkOutput("two_accepts", 64'(acceptCount), 64'd2);
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) applyStimulus();
    checkOutput("hold_pc_entry", inst_pc, 64'h8);
    repeat (5) applyStimulus();
    checkOutput("hold_valid", 64'(inst_valid), 64'h1);
    checkOutput("hold_pc", inst_pc, 64'h8);
    checkOutput("hold_inst", 64'(inst), 64'(memWord(64'h8)));
    checkOutput("hold_no_req", 64'(imem_req), 64'h0);
    inst_ready = 1'b1;
    applyStimulus();
    checkOutput("resume_req", 64'(imem_req), 64'h1);
    checkOutput("resume_addr", imem_addr, 64'hC);
    checkOutput("seq_pcs", (acceptLog.size() >= 3) ? {acceptLog[0][15:0], acceptLog[1][15:0], acceptLog[2][15:0], 16'h0} : 64'hBAD, 64'h0000_0004_0008_0000);
    checkOutput("wrap_second_addr", (wrapLog.size() >= 2) ? wrapLog[1] : 64'hBAD, 64'h0);

    memDelay = 1;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 64'h10); i++) applyStimulus();
    checkOutput("req_0x10_seen", imem_addr, 64'h10);
    redirect = 1'b1; redirect_pc = 64'h1003;
    applyStimulus();
    redirect = 1'b0;
    memDelay = 0;
    checkOutput("flush_no_req", 64'(imem_req), 64'h0);
    for (int i = 0; i < 20 && !imem_req; i++) applyStimulus();
    checkOutput("redirect_addr", imem_addr, 64'h1000);
    checkOutput("no_stale_0x10", 64'(sawStale10), 64'h0);

    for (int i = 0; i < 20 && !imem_ack; i++) applyStimulus();
    checkOutput("ack_for_coincide", 64'(imem_ack), 64'h1);
    redirect = 1'b1; redirect_pc = 64'h200;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("coincide_no_valid", 64'(inst_valid), 64'h0);
    checkOutput("coincide_req", 64'(imem_req), 64'h1);
    checkOutput("coincide_addr", imem_addr, 64'h200);

    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) applyStimulus();
    checkOutput("pre_reset_valid", 64'(inst_valid), 64'h1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("reset_clears_valid", 64'(inst_valid), 64'h0);
    checkOutput("reset_drops_req", 64'(imem_req), 64'h0);
    reset = 1'b0;
    #1;
    checkOutput("rereset_req", 64'(imem_req), 64'h1);
    checkOutput("rereset_addr", imem_addr, RESET_PC);

    memRandom = 1;
    acceptCount = 0;
    repeat (800) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom())}
                                               : {$urandom(), $urandom()};
      reset       = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    reset = 1'b0; redirect = 1'b0;
    checkOutput("random_progress", 64'(acceptCount > 40), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
